// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions for the ID/EX operand stage.
// Holds the ALU select codes, the datapath widths and the ID/EX bundle type.
package riscv_pipe_pkg;

  localparam int XLEN      = 32;
  localparam int RADDR_W   = 5;
  localparam int ALU_SEL_W = 4;

  localparam logic [ALU_SEL_W-1:0] ALU_FWD = 4'b0000;
  localparam logic [ALU_SEL_W-1:0] ALU_ADD = 4'b0001;
  localparam logic [ALU_SEL_W-1:0] ALU_AND = 4'b0010;
  localparam logic [ALU_SEL_W-1:0] ALU_OR  = 4'b0011;
  localparam logic [ALU_SEL_W-1:0] ALU_MUL = 4'b0101;
  localparam logic [ALU_SEL_W-1:0] ALU_XOR = 4'b0110;
  localparam logic [ALU_SEL_W-1:0] ALU_SLL = 4'b0111;
  localparam logic [ALU_SEL_W-1:0] ALU_SRL = 4'b1000;
  localparam logic [ALU_SEL_W-1:0] ALU_SRA = 4'b1001;

  // Everything decode hands to EX for one instruction
  typedef struct packed {
    logic [XLEN-1:0]      rs1_data;
    logic [XLEN-1:0]      rs2_data;
    logic [XLEN-1:0]      imm;
    logic [XLEN-1:0]      pc;
    logic [RADDR_W-1:0]   rs1_addr;
    logic [RADDR_W-1:0]   rs2_addr;
    logic [RADDR_W-1:0]   rd_addr;
    logic [ALU_SEL_W-1:0] alu_sel;
    logic                 use_pc;
    logic                 use_imm;
    logic                 reg_write;
    logic                 mem_read;
    logic                 mem_write;
  } id_ex_bundle_t;

endpackage

// File: rtl/operand_fwd_mux.sv
// Per-source bypass mux: picks the newest in-flight value for one register
// operand. Built only when ID_EX_FORWARD_EN is defined.
`ifdef ID_EX_FORWARD_EN
module operand_fwd_mux #(
  parameter int XLEN    = riscv_pipe_pkg::XLEN,
  parameter int RADDR_W = riscv_pipe_pkg::RADDR_W
) (
  input  logic [RADDR_W-1:0] src_addr,
  input  logic [XLEN-1:0]    reg_data,
  input  logic               exmem_we,
  input  logic [RADDR_W-1:0] exmem_rd,
  input  logic [XLEN-1:0]    exmem_result,
  input  logic               memwb_we,
  input  logic [RADDR_W-1:0] memwb_rd,
  input  logic [XLEN-1:0]    memwb_result,
  output logic [XLEN-1:0]    data
);

  // EX/MEM is the newer producer so it overrides MEM/WB; x0 is never bypassed
  always_comb begin
    data = reg_data;
    if (exmem_we && (exmem_rd == src_addr) && (src_addr != '0))
      data = exmem_result;
    else if (memwb_we && (memwb_rd == src_addr) && (src_addr != '0))
      data = memwb_result;
  end

endmodule
`endif

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register and ALU operand select with load-use stall.
// Optional feature macro: ID_EX_FORWARD_EN enables EX/MEM and MEM/WB
// bypassing; without it operands come from the latched register data and
// any pending writer of a source register stalls decode instead.
module id_ex_operand_stage #(
  parameter int XLEN      = riscv_pipe_pkg::XLEN,
  parameter int RADDR_W   = riscv_pipe_pkg::RADDR_W,
  parameter int ALU_SEL_W = riscv_pipe_pkg::ALU_SEL_W
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 FLUSH,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [XLEN-1:0]      ID_RS1_DATA,
  input  logic [XLEN-1:0]      ID_RS2_DATA,
  input  logic [XLEN-1:0]      ID_IMM,
  input  logic [XLEN-1:0]      ID_PC,
  input  logic [RADDR_W-1:0]   ID_RS1_ADDR,
  input  logic [RADDR_W-1:0]   ID_RS2_ADDR,
  input  logic [RADDR_W-1:0]   ID_RD_ADDR,
  input  logic [ALU_SEL_W-1:0] ID_ALU_SELECT,
  input  logic                 ID_USE_PC,
  input  logic                 ID_USE_IMM,
  input  logic                 ID_REG_WRITE,
  input  logic                 ID_MEM_READ,
  input  logic                 ID_MEM_WRITE,
  input  logic [RADDR_W-1:0]   EXMEM_RD_ADDR,
  input  logic                 EXMEM_REG_WRITE,
  input  logic [XLEN-1:0]      EXMEM_RESULT,
  input  logic [RADDR_W-1:0]   MEMWB_RD_ADDR,
  input  logic                 MEMWB_REG_WRITE,
  input  logic [XLEN-1:0]      MEMWB_RESULT,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [XLEN-1:0]      EX_DATA1,
  output logic [XLEN-1:0]      EX_DATA2,
  output logic [XLEN-1:0]      EX_STORE_DATA,
  output logic [ALU_SEL_W-1:0] EX_ALU_SELECT,
  output logic [RADDR_W-1:0]   EX_RD_ADDR,
  output logic                 EX_REG_WRITE,
  output logic                 EX_MEM_READ,
  output logic                 EX_MEM_WRITE,
  output logic                 LOAD_USE_STALL
);
  import riscv_pipe_pkg::*;

  id_ex_bundle_t    in_p0;
  id_ex_bundle_t    idex_p1;
  logic             vld_p1;
  logic             stall;
  logic             advance;
  logic             ex_match;
  logic [XLEN-1:0]  fwd_rs1;
  logic [XLEN-1:0]  fwd_rs2;

  // ---- p0: decode side, hazard check against the instruction held in EX
  assign in_p0 = '{rs1_data: ID_RS1_DATA, rs2_data: ID_RS2_DATA, imm: ID_IMM,
                   pc: ID_PC, rs1_addr: ID_RS1_ADDR, rs2_addr: ID_RS2_ADDR,
                   rd_addr: ID_RD_ADDR, alu_sel: ID_ALU_SELECT,
                   use_pc: ID_USE_PC, use_imm: ID_USE_IMM,
                   reg_write: ID_REG_WRITE, mem_read: ID_MEM_READ,
                   mem_write: ID_MEM_WRITE};

  assign ex_match = vld_p1 && (idex_p1.rd_addr != '0) &&
                    ((idex_p1.rd_addr == ID_RS1_ADDR) || (idex_p1.rd_addr == ID_RS2_ADDR));

`ifdef ID_EX_FORWARD_EN
  // Only a load in EX cannot be bypassed in time
  assign stall = IN_VALID && ex_match && idex_p1.mem_read;
`else
  // Without bypassing, wait until every pending writer has reached the register file
  logic exmem_match;
  logic unused_fwd;
  assign exmem_match = EXMEM_REG_WRITE && (EXMEM_RD_ADDR != '0) &&
                       ((EXMEM_RD_ADDR == ID_RS1_ADDR) || (EXMEM_RD_ADDR == ID_RS2_ADDR));
  assign stall       = IN_VALID && ((ex_match && idex_p1.reg_write) || exmem_match);
  assign unused_fwd  = ^{EXMEM_RESULT, MEMWB_RD_ADDR, MEMWB_REG_WRITE, MEMWB_RESULT,
                         idex_p1.rs1_addr, idex_p1.rs2_addr};
`endif

  assign advance        = ~vld_p1 | OUT_READY;
  assign IN_READY       = advance & ~stall;
  assign LOAD_USE_STALL = stall;

  // ---- p1: ID/EX register; flush beats hold, a stall or empty slot loads a bubble
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      vld_p1  <= 1'b0;
      idex_p1 <= '0;
    end else if (FLUSH) begin
      vld_p1            <= 1'b0;
      idex_p1.alu_sel   <= ALU_FWD;
      idex_p1.reg_write <= 1'b0;
      idex_p1.mem_read  <= 1'b0;
      idex_p1.mem_write <= 1'b0;
    end else if (advance) begin
      if (IN_VALID && !stall) begin
        vld_p1  <= 1'b1;
        idex_p1 <= in_p0;
      end else begin
        vld_p1  <= 1'b0;
        idex_p1 <= '0;
      end
    end
  end

`ifdef ID_EX_FORWARD_EN
  operand_fwd_mux #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_fwd_rs1 (
    .src_addr(idex_p1.rs1_addr), .reg_data(idex_p1.rs1_data),
    .exmem_we(EXMEM_REG_WRITE), .exmem_rd(EXMEM_RD_ADDR), .exmem_result(EXMEM_RESULT),
    .memwb_we(MEMWB_REG_WRITE), .memwb_rd(MEMWB_RD_ADDR), .memwb_result(MEMWB_RESULT),
    .data(fwd_rs1)
  );
  operand_fwd_mux #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_fwd_rs2 (
    .src_addr(idex_p1.rs2_addr), .reg_data(idex_p1.rs2_data),
    .exmem_we(EXMEM_REG_WRITE), .exmem_rd(EXMEM_RD_ADDR), .exmem_result(EXMEM_RESULT),
    .memwb_we(MEMWB_REG_WRITE), .memwb_rd(MEMWB_RD_ADDR), .memwb_result(MEMWB_RESULT),
    .data(fwd_rs2)
  );
`else
  assign fwd_rs1 = idex_p1.rs1_data;
  assign fwd_rs2 = idex_p1.rs2_data;
`endif

  // ---- EX outputs: operand select and valid-gated control
  assign EX_DATA1      = idex_p1.use_pc  ? idex_p1.pc  : fwd_rs1;
  assign EX_DATA2      = idex_p1.use_imm ? idex_p1.imm : fwd_rs2;
  assign EX_STORE_DATA = fwd_rs2;
  assign EX_ALU_SELECT = idex_p1.alu_sel;
  assign EX_RD_ADDR    = idex_p1.rd_addr;
  assign EX_REG_WRITE  = vld_p1 & idex_p1.reg_write;
  assign EX_MEM_READ   = vld_p1 & idex_p1.mem_read;
  assign EX_MEM_WRITE  = vld_p1 & idex_p1.mem_write;
  assign OUT_VALID     = vld_p1;

endmodule
